// File: rtl/qq_pkg.sv
// QuickQueue command driver shared types.
// Stats outputs are enabled with QQ_DRV_STATS_EN.
package qq_pkg;

  typedef enum logic [1:0] {
    QQ_NOP  = 2'd0,
    QQ_ENQ  = 2'd1,
    QQ_DEQ  = 2'd2,
    QQ_REPL = 2'd3
  } qq_op_e;

  typedef enum logic [1:0] {
    QQ_OK        = 2'd0,
    QQ_FULL_REJ  = 2'd1,
    QQ_EMPTY_REJ = 2'd2,
    QQ_TIMEOUT   = 2'd3
  } qq_status_e;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/qq_rsp_reg.sv
// One-entry response holding register.
// Holds status/key stable until the consumer takes it.
module qq_rsp_reg
  import qq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [1:0]   status_d,
  input  logic [W-1:0] key_d,
  input  logic         rsp_ready,
  output logic         rsp_valid,
  output logic [1:0]   rsp_status,
  output logic [W-1:0] rsp_key,
  output logic         fire
);

  assign fire = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid  <= 1'b0;
      rsp_status <= 2'd0;
      rsp_key    <= '0;
    end else if (load) begin
      rsp_valid  <= 1'b1;
      rsp_status <= status_d;
      rsp_key    <= key_d;
    end else if (fire) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/qq_cmd_driver.sv
// QuickQueue initiator: command stream to enq/deq/repl pulses.
// Optional QQ_DRV_STATS_EN adds stat_ops/stat_rej counters.
module qq_cmd_driver
  import qq_pkg::*;
#(
  parameter int W       = 8,
  parameter int TIMEOUT = 64,
  parameter int MIN_GAP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [1:0]   rsp_status,
  output logic [W-1:0] rsp_key,
  output logic         enq,
  output logic         deq,
  output logic         repl,
  output logic [W-1:0] lt_i,
  input  logic [W-1:0] lt_o,
  input  logic         rdy_t,
  input  logic         full_t,
  input  logic         empty_t
`ifdef QQ_DRV_STATS_EN
  ,
  output logic [15:0]  stat_ops,
  output logic [15:0]  stat_rej
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]   state;
  qq_op_e       op_q;
  qq_op_e       op_d;
  logic [W-1:0] rkey_q;
  logic [TW-1:0] timer;
  logic         pulsed_q;
  logic         accept;
  logic         reject;
  logic         rsp_load;
  qq_status_e   st_d;
  logic [W-1:0] key_d;
  logic         rsp_fire;

  assign op_d      = qq_op_e'(cmd_op);
  assign cmd_ready = rst & (state == S_IDLE) & rdy_t;
  assign accept    = cmd_valid & cmd_ready;

  assign enq  = (state == S_ISSUE) & (op_q == QQ_ENQ);
  assign deq  = (state == S_ISSUE) & (op_q == QQ_DEQ);
  assign repl = (state == S_ISSUE) & (op_q == QQ_REPL);

  always_comb begin
    reject   = 1'b0;
    rsp_load = 1'b0;
    st_d     = QQ_OK;
    key_d    = rkey_q;
    unique case (1'b1)
      (state == S_IDLE): begin
        unique case (op_d)
          QQ_NOP:  begin reject = 1'b1; st_d = QQ_OK; end
          QQ_ENQ:  begin reject = full_t; st_d = QQ_FULL_REJ; end
          default: begin reject = empty_t; st_d = QQ_EMPTY_REJ; end
        endcase
        rsp_load = accept & reject;
        key_d    = '0;
      end
      (state == S_WAIT): begin
        // rdy_t right after a pulse may still reflect the old op
        if (rdy_t && timer >= TW'(MIN_GAP)) begin
          rsp_load = 1'b1;
          st_d     = QQ_OK;
        end else if (timer == TW'(TIMEOUT)) begin
          rsp_load = 1'b1;
          st_d     = QQ_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      op_q     <= QQ_NOP;
      rkey_q   <= '0;
      timer    <= '0;
      pulsed_q <= 1'b0;
      lt_i     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept && reject) begin
            pulsed_q <= 1'b0;
            state    <= S_RESP;
          end else if (accept) begin
            op_q     <= op_d;
            lt_i     <= (op_d == QQ_DEQ) ? '0 : cmd_key;
            rkey_q   <= '0;
            pulsed_q <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (op_q != QQ_ENQ) rkey_q <= lt_o;
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (rsp_load) state <= S_RESP;
          else if (timer != TW'(TIMEOUT))
            timer <= timer + 1'b1;
        end
        default: begin
          if (rsp_fire) state <= S_IDLE;
        end
      endcase
    end
  end

  qq_rsp_reg #(.W(W)) u_rsp (
    .clk        (clk),
    .rst        (rst),
    .load       (rsp_load),
    .status_d   (st_d),
    .key_d      (key_d),
    .rsp_ready  (rsp_ready),
    .rsp_valid  (rsp_valid),
    .rsp_status (rsp_status),
    .rsp_key    (rsp_key),
    .fire       (rsp_fire)
  );

`ifdef QQ_DRV_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_ops <= '0;
      stat_rej <= '0;
    end else if (rsp_fire) begin
      if (pulsed_q) stat_ops <= sat_inc16(stat_ops);
      if (rsp_status != QQ_OK)
        stat_rej <= sat_inc16(stat_rej);
    end
  end
`endif

endmodule

// File: tb/tb_qq_cmd_driver.sv
// Randomized bench for qq_cmd_driver with a behavioural qq_top.
// Define QQ_DRV_STATS_EN to also check the stats counters.
module tb_qq_cmd_driver;
  localparam int W   = 8;
  localparam int TO  = 64;
  localparam int CAP = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'd0;
  logic [W-1:0] cmd_key = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_status;
  logic [W-1:0] rsp_key;
  logic         enq, deq, repl;
  logic [W-1:0] lt_i;
  logic [W-1:0] lt_o = '0;
  logic         rdy_t = 1'b1;
  logic         full_t = 1'b0;
  logic         empty_t = 1'b1;
`ifdef QQ_DRV_STATS_EN
  logic [15:0]  stat_ops, stat_rej;
`endif

  qq_cmd_driver #(.W(W), .TIMEOUT(TO), .MIN_GAP(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_key(cmd_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_key(rsp_key),
    .enq(enq), .deq(deq), .repl(repl),
    .lt_i(lt_i), .lt_o(lt_o), .rdy_t(rdy_t),
    .full_t(full_t), .empty_t(empty_t)
`ifdef QQ_DRV_STATS_EN
    , .stat_ops(stat_ops), .stat_rej(stat_rej)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int ptype;
    int lt;
    int st;
    int key;
    bit to;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   hold = 0, hold_next = 0, expect_to = 0, stall_rsp = 0;
  int   q[$];
  int   busy = 0;
  int   rlog_st[$], rlog_key[$];
  bit   seen = 0, prev_v = 0;
  int   pulse_cyc = 0;
  logic [1:0]   prev_st;
  logic [W-1:0] prev_key;
  int   exp_ops = 0, exp_rej = 0;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // behavioural qq_top: sorted list, random busy time per op
  always @(posedge clk) begin
    if (enq || deq || repl) begin
      if ((deq || repl) && q.size() > 0) void'(q.pop_front());
      if (enq || repl) begin
        int i;
        i = 0;
        while (i < q.size() && q[i] <= int'(lt_i)) i++;
        q.insert(i, int'(lt_i));
      end
      busy = $urandom_range(1, 4);
    end else if (busy > 0) busy--;
    rdy_t   <= (busy == 0) && !hold;
    full_t  <= q.size() >= CAP;
    empty_t <= q.size() == 0;
    lt_o    <= (q.size() > 0) ? W'(q[0]) : '0;
  end

  // compare process
  always @(negedge clk) begin
    exp_t e;
    int   t;
    cyc++;
    if (rst) begin
      chk("pulse_onehot", int'((int'(enq) + int'(deq) + int'(repl)) <= 1), 1);
      if (cmd_ready) chk("ready_needs_rdy", int'(rdy_t), 1);
      if (enq || deq || repl) begin
        chk("pulse_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          t = enq ? 1 : (deq ? 2 : 3);
          chk("pulse_type", t, exp_q[0].ptype);
          chk("lt_i", int'(lt_i), exp_q[0].lt);
          chk("pulse_once", int'(seen), 0);
          seen = 1;
          pulse_cyc = cyc;
        end
      end
      if (rsp_valid) begin
        chk("rsp_blocks_cmd", int'(cmd_ready), 0);
        if (prev_v) begin
          chk("rsp_status_stable", int'(rsp_status), int'(prev_st));
          chk("rsp_key_stable", int'(rsp_key), int'(prev_key));
        end else if (exp_q.size() > 0 && exp_q[0].to) begin
          chk("timeout_latency", cyc - pulse_cyc, TO + 2);
        end
        if (rsp_ready) begin
          chk("rsp_pending", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_status", int'(rsp_status), e.st);
            chk("rsp_key", int'(rsp_key), e.key);
            chk("rsp_pulsed", int'(seen), int'(e.ptype != 0));
            if (e.ptype != 0) exp_ops++;
            if (e.st != 0) exp_rej++;
          end
          rlog_st.push_back(int'(rsp_status));
          rlog_key.push_back(int'(rsp_key));
          seen = 0;
          prev_v = 0;
        end else begin
          prev_v = 1;
          prev_st = rsp_status;
          prev_key = rsp_key;
        end
      end else prev_v = 0;
      if (cmd_valid && cmd_ready) begin
        e = '{ptype: 0, lt: 0, st: 0, key: 0, to: 0};
        if (cmd_op == 2'd1) begin
          if (full_t) e.st = 1;
          else begin
            e.ptype = 1;
            e.lt = int'(cmd_key);
          end
        end else if (cmd_op != 2'd0) begin
          if (empty_t) e.st = 2;
          else begin
            e.ptype = int'(cmd_op);
            e.lt = (cmd_op == 2'd2) ? 0 : int'(cmd_key);
            e.key = int'(lt_o);
          end
        end
        if (e.ptype != 0 && expect_to) begin
          e.st = 3;
          e.to = 1;
        end
        exp_q.push_back(e);
      end
    end else begin
      prev_v = 0;
      seen = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      rsp_ready = stall_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(int op, int key);
    int n;
    n = 0;
    @(posedge clk);
    #2;
    cmd_valid = 1'b1;
    cmd_op = 2'(op);
    cmd_key = W'(key);
    @(negedge clk);
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", int'(cmd_ready), 1);
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    if (hold_next) begin
      hold = 1;
      hold_next = 0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_cmd_ready"}, int'(cmd_ready), 0);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_status"}, int'(rsp_status), 0);
    chk({tag, "_rsp_key"}, int'(rsp_key), 0);
    chk({tag, "_pulses"}, int'({enq, deq, repl}), 0);
    chk({tag, "_lt_i"}, int'(lt_i), 0);
  endtask

  int fill_keys[8] = '{5, 10, 3, 20, 30, 31, 32, 33};
  int deq_keys[8]  = '{5, 9, 10, 20, 30, 31, 32, 33};
  int base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", int'(cmd_ready), 1);

    foreach (fill_keys[i]) send(1, fill_keys[i]);
    send(1, 27);
    send(3, 9);
    repeat (8) send(2, 0);
    send(2, 0);
    drain();
    for (int i = 0; i < 8; i++) begin
      chk("enq_status", rlog_st[i], 0);
      chk("enq_key", rlog_key[i], 0);
    end
    chk("full_rej", rlog_st[8], 1);
    chk("repl_status", rlog_st[9], 0);
    chk("repl_key", rlog_key[9], 3);
    for (int i = 0; i < 8; i++)
      chk("deq_order", rlog_key[10 + i], deq_keys[i]);
    chk("empty_rej", rlog_st[18], 2);

    send(1, 40);
    drain();
    stall_rsp = 1;
    expect_to = 1;
    hold_next = 1;
    send(2, 0);
    expect_to = 0;
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", int'(rsp_valid), 1);
      chk("stall_ready", int'(cmd_ready), 0);
      chk("stall_status", int'(rsp_status), 3);
      chk("stall_key", int'(rsp_key), 40);
    end
    hold = 0;
    stall_rsp = 0;
    drain();
    chk("timeout_log", rlog_st[20], 3);

    hold_next = 1;
    send(1, 50);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outs("midreset");
    exp_q.delete();
    hold = 0;
    exp_ops = 0;
    exp_rej = 0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    base = rlog_st.size();
    send(1, 51);
    drain();
    chk("post_reset_count", rlog_st.size(), base + 1);
    chk("post_reset_status", rlog_st[base], 0);

    repeat (200) begin
      int r;
      int op;
      r = $urandom_range(0, 9);
      op = (r == 0) ? 0 : (r <= 4) ? 1 : (r <= 7) ? 2 : 3;
      send(op, $urandom_range(0, 255));
    end
    drain();

`ifdef QQ_DRV_STATS_EN
    chk("stat_ops", int'(stat_ops), exp_ops);
    chk("stat_rej", int'(stat_rej), exp_rej);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
